// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Restoring shift-subtract, one quotient bit per clock, 32 iterations.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_start  request, accepted only in IDLE or DONE
//   i_op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a      dividend
//   i_b      divisor
//   o_busy   high while iterating
//   o_valid  one-cycle pulse, result ready
//   o_result quotient or remainder, held until the next result
module div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  op_q, op_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  // Decode of the incoming request
  logic        accept;
  logic        in_signed;
  logic        div_zero;
  logic        overflow;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign accept    = i_start && (state_q != StCalc);
  assign in_signed = ~i_op[0];
  assign div_zero  = (i_b == 32'd0);
  assign overflow  = in_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign a_mag     = (in_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign b_mag     = (in_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

  // One restoring iteration
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign rem_shift = {rem_q[31:0], dvd_q[cnt_q]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_next  = rem_ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
  assign quo_next  = {quo_q[30:0], rem_ge};
  assign quo_fix   = neg_quo_q ? (32'd0 - quo_next) : quo_next;
  assign rem_fix   = neg_rem_q ? (32'd0 - rem_next[31:0]) : rem_next[31:0];

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = (div_zero || overflow) ? StDone : StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        if (cnt_q == 5'd0) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy   = (state_q == StCalc);
    o_valid  = (state_q == StDone);
    o_result = result_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      if (div_zero) begin
        result_d = i_op[1] ? i_a : 32'hFFFF_FFFF;
      end else if (overflow) begin
        result_d = i_op[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        op_d      = i_op;
        neg_quo_d = in_signed && (i_a[31] ^ i_b[31]);
        neg_rem_d = in_signed && i_a[31];
        dvd_d     = a_mag;
        dvs_d     = b_mag;
        rem_d     = 33'd0;
        quo_d     = 32'd0;
        cnt_d     = 5'd31;
      end
    end else if (state_q == StCalc) begin
      rem_d = rem_next;
      quo_d = quo_next;
      if (cnt_q == 5'd0) begin
        result_d = op_q[1] ? rem_fix : quo_fix;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= 5'd0;
      rem_q     <= 33'd0;
      quo_q     <= 32'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      result_q  <= 32'd0;
      op_q      <= 2'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_result(o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   begin sr = sa / sb; return sr; end
      2'b01:   return a / b;
      2'b10:   begin sr = sa % sb; return sr; end
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one request and waits (bounded) for o_valid; operands are scrambled after
  // acceptance so any re-latching would corrupt the result.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cnt);
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    lat = 0; busy_cnt = 0; res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      i_start = 1'b0; i_a = $urandom; i_b = $urandom; i_op = 2'($urandom);
      if (o_busy) busy_cnt++;
      if (o_valid) begin
        lat = c; res = o_result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b0; i_op = 2'd0; i_a = 32'd0; i_b = 32'd0;
    #1;
    checks++;
    if ({o_busy, o_valid, o_result} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b result=%h, want 0 0 0",
               o_busy, o_valid, o_result);
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [17] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0,
                              2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1};
    logic [31:0] as  [17] = '{100, 100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 7,
                              32'h8000_0000, 5, 5, 32'hFFFF_FFFD, 32'h8000_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'h8000_0001, 0};
    logic [31:0] bs  [17] = '{7, 7, 1, 2, 2, 32'hFFFF_FFFE, 2, 0, 0, 0, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd3, 9};
    logic [31:0] res;
    int lat, busy_cnt;
    for (int i = 0; i < 17; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat, busy_cnt);
      checks++;
      if (res !== model(ops[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL directed_result[%0d]: op=%0d a=%h b=%h got %h want %h", i, ops[i],
                 as[i], bs[i], res, model(ops[i], as[i], bs[i]));
      end
      checks++;
      if (lat != model_lat(ops[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat,
                 model_lat(ops[i], as[i], bs[i]));
      end
      checks++;
      if (busy_cnt != model_lat(ops[i], as[i], bs[i]) - 1) begin
        errors++;
        $display("FAIL directed_busy[%0d]: got %0d cycles want %0d", i, busy_cnt,
                 model_lat(ops[i], as[i], bs[i]) - 1);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    int lat, busy_cnt;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: b = 32'hFFFF_FFFF - $urandom_range(0, 5);
        default: ;
      endcase
      do_op(op, a, b, res, lat, busy_cnt);
      checks++;
      if (res !== model(op, a, b) || lat != model_lat(op, a, b)) begin
        errors++;
        $display("FAIL random[%0d]: op=%0d a=%h b=%h got %h lat %0d want %h lat %0d", i, op,
                 a, b, res, lat, model(op, a, b), model_lat(op, a, b));
      end
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0 || o_result !== model(op, a, b)) begin
        errors++;
        $display("FAIL random_hold[%0d]: got valid=%b result=%h want 0 %h", i, o_valid,
                 o_result, model(op, a, b));
      end
    end
  endtask

  task automatic test_start_while_busy;
    int valids = 0, lat = 0;
    logic [31:0] res = 32'd0;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'd1; i_a = 32'd100; i_b = 32'd7;
    for (int c = 1; c <= 45; c++) begin
      @(negedge i_clk);
      i_start = (c == 10);
      if (c == 10) begin i_op = 2'd1; i_a = 32'd9; i_b = 32'd3; end
      if (o_valid) begin
        valids++;
        if (valids == 1) begin lat = c; res = o_result; end
      end
    end
    checks++;
    if (valids != 1 || lat != 33 || res !== 32'd14) begin
      errors++;
      $display("FAIL start_while_busy: got %0d valids lat %0d result %h want 1 33 0000000e",
               valids, lat, res);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res = 32'd0;
    int lat = 0;
    bit seen = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'd1; i_a = 32'd100; i_b = 32'd7;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_valid) begin
        seen = 1'b1;
        i_start = 1'b1; i_op = 2'd1; i_a = 32'd9; i_b = 32'd3;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_first: got no o_valid within 40 cycles, want one");
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (c == 1) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy: got busy=%b after DONE-cycle start, want 1", o_busy);
        end
      end
      if (o_valid) begin lat = c; res = o_result; break; end
    end
    checks++;
    if (lat != 33 || res !== 32'd3) begin
      errors++;
      $display("FAIL b2b_second: got lat %0d result %h want 33 00000003", lat, res);
    end
    // Two special-case ops issued back-to-back give consecutive valid pulses
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'd3; i_a = 32'd5; i_b = 32'd0;
    @(negedge i_clk);
    i_op = 2'd1; i_a = 32'd5; i_b = 32'd0;
    checks++;
    if (o_valid !== 1'b1 || o_result !== 32'd5) begin
      errors++;
      $display("FAIL b2b_special1: got valid=%b result=%h want 1 00000005", o_valid, o_result);
    end
    @(negedge i_clk);
    i_start = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_result !== 32'hFFFF_FFFF || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_special2: got valid=%b busy=%b result=%h want 1 0 ffffffff",
               o_valid, o_busy, o_result);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_op;
    int valids = 0, lat, busy_cnt;
    logic [31:0] res;
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'd1; i_a = 32'd1000; i_b = 32'd3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_valid, o_result} !== 34'd0) begin
      errors++;
      $display("FAIL reset_mid_op: got busy=%b valid=%b result=%h want 0 0 0", o_busy,
               o_valid, o_result);
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid || o_busy) valids++;
    end
    checks++;
    if (valids != 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d busy/valid cycles after reset want 0", valids);
    end
    do_op(2'd1, 32'd1000, 32'd3, res, lat, busy_cnt);
    checks++;
    if (res !== 32'd333 || lat != 33) begin
      errors++;
      $display("FAIL after_reset_divu: got %h lat %0d want 0000014d lat 33", res, lat);
    end
    do_op(2'd3, 32'd1000, 32'd3, res, lat, busy_cnt);
    checks++;
    if (res !== 32'd1 || lat != 33) begin
      errors++;
      $display("FAIL after_reset_remu: got %h lat %0d want 00000001 lat 33", res, lat);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
